// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch unit: single-outstanding imem requester feeding a 2-entry {pc, inst} FIFO
module if_fetch #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                work_ena,
    input  logic                stall,
    input  logic                flush,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    output logic [PC_WIDTH-1:0] if_pc,
    output logic [31:0]         if_inst,
    output logic                if_valid
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [PC_WIDTH-1:0] fetch_pc;
    logic [PC_WIDTH-1:0] req_pc;
    logic                drop_q;

    logic [PC_WIDTH-1:0] fifo_pc   [2];
    logic [31:0]         fifo_inst [2];
    logic                rd_ptr;
    logic                wr_ptr;
    logic [1:0]          count;
    logic [1:0]          count_after;

    logic grant;
    logic resp;
    logic push;
    logic pop;
    logic issue_now;
    logic issue_after;

    assign if_valid  = (count != 2'd0);
    assign if_pc     = if_valid ? fifo_pc[rd_ptr]   : '0;
    assign if_inst   = if_valid ? fifo_inst[rd_ptr] : NOP;
    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = fetch_pc;

    // flush outranks every other event in the cycle it is seen
    assign grant = (state_q == S_REQ) && imem_gnt;
    assign resp  = (state_q == S_WAIT) && imem_rvalid;
    assign push  = resp && !drop_q && !flush;
    assign pop   = if_valid && !stall && work_ena && !flush;

    always_comb begin
        count_after = count;
        if (push && !pop) begin
            count_after = count + 2'd1;
        end else if (pop && !push) begin
            count_after = count - 2'd1;
        end
    end

    // re-issue straight out of WAIT must account for the entry landing this cycle
    assign issue_now   = work_ena && !flush && (count < 2'd2);
    assign issue_after = work_ena && !flush && (count_after < 2'd2);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (issue_now) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (grant) begin
                    state_d = S_WAIT;
                end else if (flush) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = issue_after ? S_REQ : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            drop_q   <= 1'b0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            state_q <= state_d;

            if (flush) begin
                fetch_pc <= redirect_pc;
            end else if (grant) begin
                fetch_pc <= fetch_pc + PC_WIDTH'(4);
            end

            if (grant) begin
                req_pc <= fetch_pc;
            end

            // a request still in flight at flush time returns stale data
            if (flush && (grant || ((state_q == S_WAIT) && !imem_rvalid))) begin
                drop_q <= 1'b1;
            end else if (resp) begin
                drop_q <= 1'b0;
            end

            if (flush) begin
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
                count  <= 2'd0;
            end else begin
                if (push) begin
                    fifo_pc[wr_ptr]   <= req_pc;
                    fifo_inst[wr_ptr] <= imem_rdata;
                    wr_ptr            <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                count <= count_after;
            end
        end
    end

endmodule
